// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one completed FU result per cycle and registers it onto the CDB.
// Optional macro CDB_FIXED_PRIO_EN selects strict lowest-index priority instead of round-robin.
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int ROB_DEPTH = 32,
    parameter int TAG_LEN   = $clog2(ROB_DEPTH) - 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_FU-1:0]             fu_req,
    input  logic [NUM_FU*(TAG_LEN+1)-1:0] fu_tag,
    input  logic [NUM_FU*32-1:0]          fu_result,
    output logic [NUM_FU-1:0]             fu_gnt,
    output logic                          cdb_valid,
    output logic [TAG_LEN:0]              cdb_tag,
    output logic [31:0]                   cdb_result,
    output logic                          conflict
);

    localparam int TW    = TAG_LEN + 1;
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic             found;
    logic [PTR_W-1:0] win;
    logic             grant;

`ifdef CDB_FIXED_PRIO_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!found && fu_req[k]) begin
                found = 1'b1;
                win   = PTR_W'(k);
            end
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W:0]   idx;
    logic [PTR_W:0]   nxt;

    // Search starts at rr_ptr and wraps; idx is one bit wider so the wrap compare cannot overflow.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_FU)) idx = idx - (PTR_W+1)'(NUM_FU);
            if (!found && fu_req[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        nxt      = {1'b0, win} + (PTR_W+1)'(1);
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (nxt == (PTR_W+1)'(NUM_FU)) ? '0 : nxt[PTR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr_q <= '0;
        else      rr_ptr_q <= rr_ptr_d;
    end
`endif

    // Grant is suppressed during reset so FUs never see a consumed result that gets dropped.
    assign grant = found && !flush && rst;

    always_comb begin
        fu_gnt = '0;
        if (grant) fu_gnt[win] = 1'b1;
    end

    logic            cdb_valid_q, cdb_valid_d;
    logic [TW-1:0]   cdb_tag_q, cdb_tag_d;
    logic [31:0]     cdb_result_q, cdb_result_d;
    logic            conflict_q, conflict_d;

    // One-hot grant makes an AND-OR mux sufficient; with no grant the bus holds its last value.
    always_comb begin
        cdb_valid_d  = grant;
        cdb_tag_d    = grant ? '0 : cdb_tag_q;
        cdb_result_d = grant ? '0 : cdb_result_q;
        for (int k = 0; k < NUM_FU; k++) begin
            if (fu_gnt[k]) begin
                cdb_tag_d    = cdb_tag_d    | fu_tag[k*TW +: TW];
                cdb_result_d = cdb_result_d | fu_result[k*32 +: 32];
            end
        end
        conflict_d = ($countones(fu_req) > 1) && !flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_result_q <= '0;
            conflict_q   <= 1'b0;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_result_q <= cdb_result_d;
            conflict_q   <= conflict_d;
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_tag    = cdb_tag_q;
    assign cdb_result = cdb_result_q;
    assign conflict   = conflict_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (NUM_FU=4, ROB_DEPTH=32).
module tb_cdb_arbiter;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [3:0]   fu_req;
    logic [19:0]  fu_tag;
    logic [127:0] fu_result;
    logic [3:0]   fu_gnt;
    logic         cdb_valid;
    logic [4:0]   cdb_tag;
    logic [31:0]  cdb_result;
    logic         conflict;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_arbiter #(.NUM_FU(4), .ROB_DEPTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fu_req     (fu_req),
        .fu_tag     (fu_tag),
        .fu_result  (fu_result),
        .fu_gnt     (fu_gnt),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_result (cdb_result),
        .conflict   (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // FU i carries tag 10+i and result A000_000i unless a test overrides it.
    task automatic load_default_data();
        for (int i = 0; i < 4; i++) begin
            fu_tag[i*5 +: 5]     = 5'(10 + i);
            fu_result[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; fu_req = 4'b0000; flush = 1'b0;
        load_default_data();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; fu_req = 4'b1111;
        load_default_data();
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (fu_gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: got %b want 0000", fu_gnt); end
        n_tests++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", cdb_valid); end
        n_tests++; if (cdb_tag !== 5'd0 || cdb_result !== 32'd0) begin n_fail++; $display("FAIL rst_data: got tag %0d res %h want 0 0", cdb_tag, cdb_result); end
        n_tests++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL rst_conflict: got %b want 0", conflict); end
        rst = 1'b1; #1;
        n_tests++; if (fu_gnt !== 4'b0001) begin n_fail++; $display("FAIL rel_gnt: got %b want 0001", fu_gnt); end
        @(posedge clk); #1;
        n_tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'd10) begin n_fail++; $display("FAIL rel_cdb: got v%b tag %0d want v1 tag 10", cdb_valid, cdb_tag); end
        fu_req = 4'b0000;
    endtask

    task automatic test_rotation();
        logic [3:0] eg;
        int e;
        do_reset();
        fu_req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
`ifdef CDB_FIXED_PRIO_EN
            e = 0;
`else
            e = c % 4;
`endif
            eg = 4'b0001 << e;
            #1;
            n_tests++; if (fu_gnt !== eg) begin n_fail++; $display("FAIL rot_gnt[%0d]: got %b want %b", c, fu_gnt, eg); end
            @(posedge clk); #1;
            n_tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'(10 + e) || cdb_result !== 32'hA000_0000 + 32'(e)) begin
                n_fail++; $display("FAIL rot_cdb[%0d]: got v%b tag %0d res %h want v1 tag %0d", c, cdb_valid, cdb_tag, cdb_result, 10 + e);
            end
            n_tests++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL rot_conflict[%0d]: got %b want 1", c, conflict); end
        end
        fu_req = 4'b0000;
        @(posedge clk); #1;
`ifdef CDB_FIXED_PRIO_EN
        e = 0;
`else
        e = 3;
`endif
        n_tests++; if (cdb_valid !== 1'b0 || cdb_tag !== 5'(10 + e)) begin n_fail++; $display("FAIL rot_idle: got v%b tag %0d want v0 tag %0d", cdb_valid, cdb_tag, 10 + e); end
        n_tests++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL rot_idle_conflict: got %b want 0", conflict); end
    endtask

    task automatic test_wrap();
        logic [3:0] reqs [3];
        logic [3:0] gnts [3];
        reqs = '{4'b0100, 4'b0101, 4'b0101};
        gnts = '{4'b0100, 4'b0001, 4'b0100};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            fu_req = reqs[c]; #1;
            n_tests++; if (fu_gnt !== gnts[c]) begin n_fail++; $display("FAIL wrap_gnt[%0d]: got %b want %b", c, fu_gnt, gnts[c]); end
            @(posedge clk); #1;
        end
        n_tests++; if (cdb_tag !== 5'd12) begin n_fail++; $display("FAIL wrap_tag: got %0d want 12", cdb_tag); end
        fu_req = 4'b0000;
    endtask

    task automatic test_datapath();
        do_reset();
        fu_tag[10 +: 5] = 5'd17;
        fu_result[64 +: 32] = 32'hDEAD_BEEF;
        fu_req = 4'b0100; #1;
        n_tests++; if (fu_gnt !== 4'b0100) begin n_fail++; $display("FAIL dp_gnt: got %b want 0100", fu_gnt); end
        @(posedge clk); #1;
        fu_req = 4'b0000;
        n_tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'd17 || cdb_result !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL dp_cdb: got v%b tag %0d res %h want v1 tag 17 res deadbeef", cdb_valid, cdb_tag, cdb_result);
        end
        n_tests++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL dp_conflict: got %b want 0", conflict); end
        @(posedge clk); #1;
        n_tests++; if (cdb_valid !== 1'b0 || cdb_tag !== 5'd17 || cdb_result !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL dp_idle: got v%b tag %0d res %h want v0 tag 17 res deadbeef", cdb_valid, cdb_tag, cdb_result);
        end
        load_default_data();
    endtask

    task automatic test_flush();
        do_reset();
        fu_req = 4'b0001;
        @(posedge clk); #1;
        fu_req = 4'b0110; flush = 1'b1; #1;
        n_tests++; if (fu_gnt !== 4'b0000) begin n_fail++; $display("FAIL fl_gnt: got %b want 0000", fu_gnt); end
        n_tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'd10) begin n_fail++; $display("FAIL fl_visible: got v%b tag %0d want v1 tag 10", cdb_valid, cdb_tag); end
        @(posedge clk); #1;
        flush = 1'b0;
        n_tests++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", cdb_valid); end
        n_tests++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL fl_conflict: got %b want 0", conflict); end
        #1;
        n_tests++; if (fu_gnt !== 4'b0010) begin n_fail++; $display("FAIL fl_resume_gnt: got %b want 0010", fu_gnt); end
        @(posedge clk); #1;
        fu_req = 4'b0000;
        n_tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'd11 || conflict !== 1'b1) begin
            n_fail++; $display("FAIL fl_resume_cdb: got v%b tag %0d c%b want v1 tag 11 c1", cdb_valid, cdb_tag, conflict);
        end
    endtask

    task automatic test_hold();
        int got_cycle;
        do_reset();
        got_cycle = -1;
        fu_req = 4'b0011;
        for (int c = 0; c < 4 && got_cycle < 0; c++) begin
            #1;
            if (fu_gnt[1]) got_cycle = c;
            @(posedge clk); #1;
            if (got_cycle < 0) begin
                n_tests++; if (fu_tag[5 +: 5] !== 5'd11) begin n_fail++; $display("FAIL hold_tag: got %0d want 11", fu_tag[5 +: 5]); end
            end
        end
        n_tests++; if (got_cycle != 1) begin n_fail++; $display("FAIL hold_gnt_cycle: got %0d want 1", got_cycle); end
        n_tests++; if (cdb_tag !== 5'd11 || cdb_valid !== 1'b1) begin n_fail++; $display("FAIL hold_cdb: got v%b tag %0d want v1 tag 11", cdb_valid, cdb_tag); end
        fu_req = 4'b0000;
    endtask

    task automatic test_single_and_midreset();
        do_reset();
        fu_req = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++; if (fu_gnt !== 4'b1000) begin n_fail++; $display("FAIL single_gnt[%0d]: got %b want 1000", c, fu_gnt); end
            @(posedge clk); #1;
        end
        fu_req = 4'b1111; #1;
        n_tests++; if (fu_gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_pre_gnt: got %b want 0001", fu_gnt); end
        @(posedge clk); #1;
        rst = 1'b0; #1;
        n_tests++; if (fu_gnt !== 4'b0000 || cdb_valid !== 1'b0 || cdb_tag !== 5'd0) begin
            n_fail++; $display("FAIL mid_rst: got g%b v%b tag %0d want g0000 v0 tag 0", fu_gnt, cdb_valid, cdb_tag);
        end
        @(posedge clk); #1;
        rst = 1'b1; #1;
        n_tests++; if (fu_gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_after_gnt: got %b want 0001", fu_gnt); end
        fu_req = 4'b0000;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; fu_req = 4'b0000;
        fu_tag = '0; fu_result = '0;
        test_reset();
        test_rotation();
`ifndef CDB_FIXED_PRIO_EN
        test_wrap();
        test_hold();
`endif
        test_datapath();
        test_flush();
        test_single_and_midreset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
